systolic_array_driver: RTL and testbench

- Single-clock front/back end for the 3-slice systolic MAC chain; each slice computes y <= yin + w*x on its clock edge.
- Accepts one input vector per handshake (x1..x3, yin) and skews x into the chain one slice per cycle.
- Holds the weights stable; captures the chain output into a result FIFO and returns it over a valid/ready master port.
- Its array-side outputs feed all three slices; all slice clocks are tied to clk.

---
 rtl/systolic_array_driver_pkg.sv | 23 ++
 rtl/systolic_array_driver_fifo.sv | 71 +++++++
 rtl/systolic_array_driver.sv | 156 +++++++++++++++
 tb/tb_systolic_array_driver.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_driver_pkg.sv
// Shared definitions for the systolic array driver: pipeline depth,
// FSM state encoding and FIFO sizing helpers.
package systolic_array_driver_pkg;

    localparam int STAGES  = 3;
    localparam int LATENCY = STAGES + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to hold an occupancy count from 0 up to depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/systolic_array_driver_fifo.sv
// Synchronous result FIFO with occupancy count. A push while full is only
// taken when a pop frees the head in the same cycle; a pop while empty is
// ignored, so push and pop together at either boundary are safe.
module sync_fifo
    import systolic_array_driver_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; reset discards every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/systolic_array_driver.sv
// Front/back end for a 3-slice systolic MAC chain. Vectors are accepted one
// per cycle, x is skewed one slice per cycle, and the chain output is
// captured LATENCY edges after accept into a result FIFO. A credit count
// (in-flight plus queued) keeps the FIFO from ever overflowing.
module systolic_array_driver
    import systolic_array_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [WIDTH-1:0]     w_in1,
    input  logic [WIDTH-1:0]     w_in2,
    input  logic [WIDTH-1:0]     w_in3,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_x1,
    input  logic [WIDTH-1:0]     s_x2,
    input  logic [WIDTH-1:0]     s_x3,
    input  logic [2*WIDTH-1:0]   s_yin,
    output logic [WIDTH-1:0]     a_w1,
    output logic [WIDTH-1:0]     a_w2,
    output logic [WIDTH-1:0]     a_w3,
    output logic [WIDTH-1:0]     a_x1,
    output logic [WIDTH-1:0]     a_x2,
    output logic [WIDTH-1:0]     a_x3,
    output logic [2*WIDTH-1:0]   a_yin,
    input  logic [2*WIDTH-1:0]   a_y,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*WIDTH-1:0]   m_y
);

    localparam int YW = 2 * WIDTH;
    localparam int CW = fifo_cnt_w(FIFO_DEPTH);
    localparam int IW = fifo_cnt_w(LATENCY);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    state_t             state_r;
    state_t             state_s;
    logic [LATENCY-1:0] valid_r;
    logic [WIDTH-1:0]   x2_skew_r;
    logic [WIDTH-1:0]   x3_skew1_r;
    logic [WIDTH-1:0]   x3_skew2_r;
    logic [IW-1:0]      inflight_s;
    logic [SW-1:0]      credit_sum_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               w_load_s;
    logic               accept_s;
    logic               pop_s;

    assign w_ready      = (state_r == IDLE);
    assign w_load_s     = w_valid && w_ready;
    assign credit_sum_s = SW'(inflight_s) + SW'(fifo_count_s);
    assign s_ready      = (credit_sum_s < SW'(FIFO_DEPTH)) && !fifo_full_s && !w_load_s;
    assign accept_s     = s_valid && s_ready;
    assign m_valid      = !fifo_empty_s;
    assign pop_s        = m_valid && m_ready;

    // Number of vectors currently travelling through the chain.
    always_comb begin
        inflight_s = {IW{1'b0}};
        for (int i = 0; i < LATENCY; i++) begin
            inflight_s = inflight_s + IW'(valid_r[i]);
        end
    end

    // Next state: RUN while anything is in flight or being accepted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!accept_s && (valid_r[LATENCY-2:0] == {(LATENCY-1){1'b0}})) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Weight registers: loaded only while no vector is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_w1 <= {WIDTH{1'b0}};
            a_w2 <= {WIDTH{1'b0}};
            a_w3 <= {WIDTH{1'b0}};
        end else if (w_load_s) begin
            a_w1 <= w_in1;
            a_w2 <= w_in2;
            a_w3 <= w_in3;
        end
    end

    // Skew pipeline: stage k drives its slice one cycle after stage k-1;
    // stages without a valid vector drive zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r    <= {LATENCY{1'b0}};
            a_x1       <= {WIDTH{1'b0}};
            a_yin      <= {YW{1'b0}};
            a_x2       <= {WIDTH{1'b0}};
            a_x3       <= {WIDTH{1'b0}};
            x2_skew_r  <= {WIDTH{1'b0}};
            x3_skew1_r <= {WIDTH{1'b0}};
            x3_skew2_r <= {WIDTH{1'b0}};
        end else begin
            valid_r    <= {valid_r[LATENCY-2:0], accept_s};
            a_x1       <= accept_s ? s_x1  : {WIDTH{1'b0}};
            a_yin      <= accept_s ? s_yin : {YW{1'b0}};
            x2_skew_r  <= accept_s ? s_x2  : {WIDTH{1'b0}};
            x3_skew1_r <= accept_s ? s_x3  : {WIDTH{1'b0}};
            a_x2       <= valid_r[0] ? x2_skew_r  : {WIDTH{1'b0}};
            x3_skew2_r <= valid_r[0] ? x3_skew1_r : {WIDTH{1'b0}};
            a_x3       <= valid_r[1] ? x3_skew2_r : {WIDTH{1'b0}};
        end
    end

    sync_fifo #(
        .WIDTH (YW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_r[LATENCY-1]),
        .din   (a_y),
        .pop   (pop_s),
        .dout  (m_y),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule

// File: tb/tb_systolic_array_driver.sv
// Bench for systolic_array_driver: models the external 3-slice MAC chain,
// predicts every result from the accepted vector and the weights loaded at
// that time, and runs directed tables, corner sequences and random traffic.
module tb_systolic_array_driver;

    logic               clk;
    logic               rst;
    logic               w_valid, w_ready;
    logic signed [7:0]  w_in1, w_in2, w_in3;
    logic               s_valid, s_ready;
    logic signed [7:0]  s_x1, s_x2, s_x3;
    logic signed [15:0] s_yin;
    logic signed [7:0]  a_w1, a_w2, a_w3, a_x1, a_x2, a_x3;
    logic signed [15:0] a_yin, a_y;
    logic               m_valid, m_ready;
    logic signed [15:0] m_y;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;

    logic signed [15:0] exp_q [$];
    logic signed [7:0]  mw1, mw2, mw3;
    logic signed [15:0] y1, y2, y3;
    logic signed [15:0] e_v;

    typedef struct {
        logic signed [7:0]  w1, w2, w3, x1, x2, x3;
        logic signed [15:0] yin, y;
    } vec_t;
    vec_t tbl [7];

    systolic_array_driver #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_in1(w_in1), .w_in2(w_in2), .w_in3(w_in3),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_x1(s_x1), .s_x2(s_x2), .s_x3(s_x3), .s_yin(s_yin),
        .a_w1(a_w1), .a_w2(a_w2), .a_w3(a_w3),
        .a_x1(a_x1), .a_x2(a_x2), .a_x3(a_x3), .a_yin(a_yin),
        .a_y(a_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] mul(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [15:0] ea, eb;
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
        return ea * eb;
    endfunction

    // External MAC chain: y <= yin + w*x per slice, all on clk.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            y1 <= 16'sd0; y2 <= 16'sd0; y3 <= 16'sd0;
        end else begin
            y1 <= a_yin + mul(a_w1, a_x1);
            y2 <= y1 + mul(a_w2, a_x2);
            y3 <= y2 + mul(a_w3, a_x3);
        end
    end
    assign a_y = y3;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: inputs are stable at negedge, so handshakes seen here are
    // the ones taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(m_y), 99999);
                end else begin
                    e_v = exp_q.pop_front();
                    chk("model_result", int'(m_y), int'(e_v));
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_yin + mul(mw1, s_x1) + mul(mw2, s_x2) + mul(mw3, s_x3));
            end
            if (w_valid && w_ready) begin
                mw1 = w_in1; mw2 = w_in2; mw3 = w_in3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        w_valid = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        mw1 = 8'sd0; mw2 = 8'sd0; mw3 = 8'sd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic load_w(input logic signed [7:0] a, input logic signed [7:0] b, input logic signed [7:0] c);
        logic ok;
        int n;
        w_valid = 1'b1; w_in1 = a; w_in2 = b; w_in3 = c;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            #1;
            ok = w_ready;
            step();
            n++;
        end
        w_valid = 1'b0;
        chk("w_load_bound", int'(ok), 1);
    endtask

    task automatic send(input logic signed [7:0] x1, input logic signed [7:0] x2,
                        input logic signed [7:0] x3, input logic signed [15:0] yin);
        logic ok;
        int n;
        s_valid = 1'b1; s_x1 = x1; s_x2 = x2; s_x3 = x3; s_yin = yin;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            #1;
            ok = s_ready;
            step();
            n++;
        end
        s_valid = 1'b0;
        chk("send_bound", int'(ok), 1);
    endtask

    task automatic wait_mvalid(output int n);
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        chk("m_valid_bound", int'(m_valid), 1);
    endtask

    task automatic drain();
        int n;
        m_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_m_valid", int'(m_valid), 0);
    endtask

    initial begin
        int n, acc, base, seen;
        tbl[0] = '{8'sd2, 8'sd3, 8'sd4, 8'sd1, 8'sd1, 8'sd1, 16'sd0, 16'sd9};
        tbl[1] = '{8'sd2, 8'sd3, 8'sd4, -8'sd1, 8'sd2, -8'sd3, 16'sd10, 16'sd2};
        tbl[2] = '{8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd0, 8'sd0, 16'sd0, 16'sd10};
        tbl[3] = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 16'sd0, -16'sd17149};
        tbl[4] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, 16'sd0, -16'sd16384};
        tbl[5] = '{8'sd1, -8'sd1, 8'sd1, 8'sd100, 8'sd50, -8'sd20, -16'sd300, -16'sd270};
        tbl[6] = '{-8'sd128, 8'sd127, 8'sd0, 8'sd127, -8'sd128, 8'sd55, 16'sd32767, 16'sd255};

        w_in1 = 8'sd0; w_in2 = 8'sd0; w_in3 = 8'sd0;
        s_x1 = 8'sd0; s_x2 = 8'sd0; s_x3 = 8'sd0; s_yin = 16'sd0;
        m_ready = 1'b0;
        apply_reset();

        // Reset state.
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_y", int'(m_y), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_w_ready", int'(w_ready), 1);
        chk("rst_weights", int'((a_w1 != 0) || (a_w2 != 0) || (a_w3 != 0)), 0);
        chk("rst_array", int'((a_x1 != 0) || (a_x2 != 0) || (a_x3 != 0) || (a_yin != 0)), 0);

        // Directed table: one vector at a time, fixed 4-edge latency.
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load_w(tbl[i].w1, tbl[i].w2, tbl[i].w3);
            send(tbl[i].x1, tbl[i].x2, tbl[i].x3, tbl[i].yin);
            wait_mvalid(n);
            chk("tbl_latency", n, 4);
            chk("tbl_y", int'(m_y), int'(tbl[i].y));
            chk("tbl_bubble", int'((a_x1 != 0) || (a_x2 != 0) || (a_x3 != 0) || (a_yin != 0)), 0);
            step();
        end

        // Back-to-back vectors come out on consecutive cycles.
        load_w(8'sd2, 8'sd3, 8'sd4);
        s_valid = 1'b1; s_x1 = -8'sd1; s_x2 = 8'sd2; s_x3 = -8'sd3; s_yin = 16'sd10;
        #1; chk("b2b_ready0", int'(s_ready), 1);
        step();
        s_x1 = 8'sd5; s_x2 = 8'sd0; s_x3 = 8'sd0; s_yin = 16'sd0;
        #1; chk("b2b_ready1", int'(s_ready), 1);
        step();
        s_valid = 1'b0;
        wait_mvalid(n);
        chk("b2b_y0", int'(m_y), 2);
        step();
        chk("b2b_valid1", int'(m_valid), 1);
        chk("b2b_y1", int'(m_y), 10);
        drain();

        // Credit limit: with m_ready low only FIFO_DEPTH vectors get in.
        m_ready = 1'b0;
        base = out_cnt;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_x1 = 8'(i + 1); s_x2 = 8'(2 * i); s_x3 = 8'(-i); s_yin = 16'(100 * i);
            #1;
            if (s_ready) acc++;
            step();
        end
        chk("credit_accepts", acc, 4);
        #1; chk("credit_s_ready", int'(s_ready), 0);
        s_valid = 1'b0;
        chk("credit_m_valid", int'(m_valid), 1);
        drain();
        chk("credit_outputs", out_cnt - base, 4);

        // Weight load is held off while vectors are in flight.
        load_w(8'sd2, 8'sd3, 8'sd4);
        send(8'sd1, 8'sd2, 8'sd3, 16'sd5);
        send(-8'sd4, 8'sd6, 8'sd1, 16'sd0);
        w_valid = 1'b1; w_in1 = 8'sd9; w_in2 = -8'sd8; w_in3 = 8'sd7;
        #1; chk("wload_blocked", int'(w_ready), 0);
        n = 0;
        while (!w_ready && n < 30) begin
            step();
            n++;
        end
        chk("wload_wait_bound", int'(w_ready), 1);
        s_valid = 1'b1; s_x1 = 8'sd1; s_x2 = 8'sd1; s_x3 = 8'sd1; s_yin = 16'sd0;
        #1; chk("wload_wins", int'(s_ready), 0);
        step();
        w_valid = 1'b0;
        chk("wload_w1", int'(a_w1), 9);
        chk("wload_w2", int'(a_w2), -8);
        chk("wload_w3", int'(a_w3), 7);
        #1; chk("wload_then_accept", int'(s_ready), 1);
        step();
        s_valid = 1'b0;
        drain();

        // Reset with 3 vectors in flight and 1 result queued.
        m_ready = 1'b0;
        send(8'sd1, 8'sd1, 8'sd1, 16'sd0);
        wait_mvalid(n);
        send(8'sd2, 8'sd2, 8'sd2, 16'sd1);
        send(8'sd3, 8'sd3, 8'sd3, 16'sd2);
        send(8'sd4, 8'sd4, 8'sd4, 16'sd3);
        #3;
        apply_reset();
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        chk("mid_rst_w_ready", int'(w_ready), 1);
        chk("mid_rst_weights", int'((a_w1 != 0) || (a_w2 != 0) || (a_w3 != 0)), 0);
        m_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_valid) seen++;
        end
        chk("mid_rst_no_output", seen, 0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 800; i++) begin
            w_valid = ($urandom_range(0, 15) == 0);
            w_in1 = 8'($urandom); w_in2 = 8'($urandom); w_in3 = 8'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
            s_x1 = 8'($urandom); s_x2 = 8'($urandom); s_x3 = 8'($urandom);
            s_yin = 16'($urandom);
            m_ready = (i % 200 < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
            step();
        end
        w_valid = 1'b0;
        s_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
